// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: forwarding select codes,
// tracking-entry slot indices and the select priority helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int N_ENT      = 3;
    localparam int ENT_EX     = 0;
    localparam int ENT_MEM    = 1;
    localparam int ENT_WB     = 2;
    localparam int ENT_FLAG_W = 1;

    // Younger producer wins; WB is covered by the write-first regfile.
    function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit) return FWD_EXMEM;
        if (mem_hit) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Destination-vs-source comparator for one tracking entry and one operand.
module hazard_match #(
    parameter int AW = 5
) (
    input  logic          ent_valid,
    input  logic          ent_we,
    input  logic [AW-1:0] ent_rd,
    input  logic [AW-1:0] rs,
    input  logic          rs_used,
    output logic          hit
);

    assign hit = ent_valid && ent_we && (ent_rd != '0) && (ent_rd == rs) && rs_used;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: tracks EX/MEM/WB producers and
// drives stall, flush, registered forwarding selects and a stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              fwd_mode,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_count
);

    logic [N_ENT-1:0]             vld_q, vld_d;
    logic [N_ENT-1:0]             we_q, we_d;
    logic [N_ENT-1:0]             ld_q, ld_d;
    logic [N_ENT-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [N_ENT-1:0]             hit1, hit2;
    logic [1:0]                   sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         stall_raw, issue;
    logic                         unused_wb;

    genvar e;
    for (e = 0; e < N_ENT; e++) begin : g_ent
        hazard_match #(.AW(REG_AW)) u_rs1 (
            .ent_valid (vld_q[e]),
            .ent_we    (we_q[e]),
            .ent_rd    (rd_q[e]),
            .rs        (id_rs1),
            .rs_used   (id_rs1_used),
            .hit       (hit1[e])
        );
        hazard_match #(.AW(REG_AW)) u_rs2 (
            .ent_valid (vld_q[e]),
            .ent_we    (we_q[e]),
            .ent_rd    (rd_q[e]),
            .rs        (id_rs2),
            .rs_used   (id_rs2_used),
            .hit       (hit2[e])
        );
    end

    // WB matches resolve through the write-first regfile and need no action.
    assign unused_wb = hit1[ENT_WB] | hit2[ENT_WB] | ld_q[ENT_WB];

    always_comb begin
        stall_raw   = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        sel1_d      = FWD_RF;
        sel2_d      = FWD_RF;
        cnt_d       = cnt_q;

        if (fwd_mode)
            stall_raw = ld_q[ENT_EX] && (hit1[ENT_EX] || hit2[ENT_EX]);
        else
            stall_raw = hit1[ENT_EX] || hit2[ENT_EX] || hit1[ENT_MEM] || hit2[ENT_MEM];

        // Redirect beats stall; both are silenced while reset is held.
        stall_if_id = !cpu_rst && id_valid && !ex_redirect && stall_raw;
        flush_if_id = !cpu_rst && ex_redirect;
        flush_id_ex = !cpu_rst && ex_redirect;
        issue       = id_valid && !stall_if_id && !ex_redirect;

        vld_d = {vld_q[ENT_MEM], vld_q[ENT_EX], issue};
        we_d  = {we_q[ENT_MEM],  we_q[ENT_EX],  issue && id_we};
        ld_d  = {ld_q[ENT_MEM],  ld_q[ENT_EX],  issue && id_is_load};
        rd_d  = {rd_q[ENT_MEM],  rd_q[ENT_EX],  id_rd};

        if (fwd_mode && !stall_if_id && !ex_redirect) begin
            sel1_d = pick_sel(hit1[ENT_EX], hit1[ENT_MEM]);
            sel2_d = pick_sel(hit2[ENT_EX], hit2[ENT_MEM]);
        end

        if (stall_if_id && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            vld_q  <= '0;
            we_q   <= '0;
            ld_q   <= '0;
            rd_q   <= '0;
            sel1_q <= FWD_RF;
            sel2_q <= FWD_RF;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            we_q   <= we_d;
            ld_q   <= ld_d;
            rd_q   <= rd_d;
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fwd_rs1_sel = sel1_q;
    assign fwd_rs2_sel = sel2_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected results are queued as each ID
// instruction is driven and compared when the DUT presents them.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic          id_we = 1'b0, id_is_load = 1'b0;
    logic          ex_redirect = 1'b0, fwd_mode = 1'b1;
    logic          stall_if_id, flush_if_id, flush_id_ex;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
    logic [CW-1:0] stall_count;

    hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .fwd_mode    (fwd_mode),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .fwd_rs1_sel (fwd_rs1_sel),
        .fwd_rs2_sel (fwd_rs2_sel),
        .stall_count (stall_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic we; logic ld; logic redir;
        logic stall; logic flush; logic [1:0] s1; logic [1:0] s2;
    } step_t;

    typedef struct {
        logic stall; logic flush; logic [1:0] s1; logic [1:0] s2; logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cnt = '0;

    function automatic step_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic we, input logic ld, input logic redir,
                                 input logic stall, input logic flush,
                                 input logic [1:0] s1, input logic [1:0] s2);
        step_t s;
        s = '{v, rs1, u1, rs2, u2, rd, we, ld, redir, stall, flush, s1, s2};
        return s;
    endfunction

    function automatic step_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endfunction

    // Apply one ID-stage cycle and queue what the DUT should show for it.
    task automatic drive(input step_t s);
        id_valid = s.v; id_rs1 = s.rs1; id_rs1_used = s.u1;
        id_rs2 = s.rs2; id_rs2_used = s.u2; id_rd = s.rd;
        id_we = s.we; id_is_load = s.ld; ex_redirect = s.redir;
        if (s.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        sb.push_back('{s.stall, s.flush, s.s1, s.s2, exp_cnt});
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        fwd_mode = 1'b1;
        drive(mk(1, 5, 1, 5, 1, 6, 1, 1, 1, 0, 0, 2'b00, 2'b00));
        void'(sb.pop_front());
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        n_chk++;
        if (stall_if_id !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got stall=%b flush=%b/%b want 0 0/0",
                     stall_if_id, flush_if_id, flush_id_ex);
        end
        n_chk++;
        if (fwd_rs1_sel !== 2'b00 || fwd_rs2_sel !== 2'b00 || stall_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got sel=%b/%b cnt=%0d want 00/00 0",
                     fwd_rs1_sel, fwd_rs2_sel, stall_count);
        end
        @(posedge cpu_clk); #1;
        exp_cnt = '0;
        drive(bub());
        void'(sb.pop_front());
        cpu_rst = 1'b0;
        repeat (3) begin
            @(posedge cpu_clk); #1;
        end
    endtask

    task automatic test_no_hazard();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b1;
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL no_hazard[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL no_hazard[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b1;
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b01, 2'b00));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b1;
        seq.push_back(mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b10));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL load_use[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL load_use[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    task automatic test_stall_only();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b0;
        seq.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL stall_only[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL stall_only[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    // The flushed add must never reach EX, while the redirecting load moves on to MEM.
    task automatic test_redirect();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b1;
        seq.push_back(mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00));
        seq.push_back(mk(1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b10));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL redirect[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL redirect[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    task automatic test_x0();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b1;
        seq.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        seq.push_back(mk(1, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL x0[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL x0[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
    endtask

    // Repeated distance-1 pairs in stall-only mode push the counter past all-ones.
    task automatic test_saturate();
        step_t seq[$];
        exp_t  e;
        fwd_mode = 1'b0;
        repeat (7) begin
            seq.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
            seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00));
            seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 2'b00, 2'b00));
            seq.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        end
        repeat (3) seq.push_back(bub());
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge cpu_clk);
            e = sb.pop_front();
            n_chk++;
            if (stall_if_id !== e.stall || flush_if_id !== e.flush || flush_id_ex !== e.flush) begin
                n_fail++;
                $display("FAIL saturate[%0d] ctl: got stall=%b flush=%b/%b want %b %b",
                         i, stall_if_id, flush_if_id, flush_id_ex, e.stall, e.flush);
            end
            @(posedge cpu_clk); #1;
            n_chk++;
            if (fwd_rs1_sel !== e.s1 || fwd_rs2_sel !== e.s2 || stall_count !== e.cnt) begin
                n_fail++;
                $display("FAIL saturate[%0d] sel: got %b/%b cnt=%0d want %b/%b cnt=%0d",
                         i, fwd_rs1_sel, fwd_rs2_sel, stall_count, e.s1, e.s2, e.cnt);
            end
        end
        n_chk++;
        if (stall_count !== 4'hF) begin
            n_fail++;
            $display("FAIL saturate_final: got cnt=%0d want 15", stall_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        fwd_mode = 1'b1;
        drive(mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        void'(sb.pop_front());
        @(posedge cpu_clk); #1;
        drive(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        void'(sb.pop_front());
        @(negedge cpu_clk);
        n_chk++;
        if (stall_if_id !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got stall=%b want 1", stall_if_id);
        end
        cpu_rst = 1'b1;
        #1;
        n_chk++;
        if (stall_if_id !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got stall=%b flush=%b/%b want 0 0/0",
                     stall_if_id, flush_if_id, flush_id_ex);
        end
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        n_chk++;
        if (stall_if_id !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 ||
            fwd_rs1_sel !== 2'b00 || fwd_rs2_sel !== 2'b00 || stall_count !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got stall=%b flush=%b/%b sel=%b/%b cnt=%0d want all 0",
                     stall_if_id, flush_if_id, flush_id_ex, fwd_rs1_sel, fwd_rs2_sel, stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_back_to_back();
        test_load_use();
        test_stall_only();
        test_redirect();
        test_x0();
        test_saturate();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
